// File: rtl/inv_ntt_core.sv
// Kyber inverse NTT (q=3329, n=256): streams in 256 NTT-domain coefficients, runs the
// in-place Gentleman-Sande butterflies and the final 128^-1 scaling, then streams the result out.
module inv_ntt_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data,
    output logic        busy
);
    localparam logic [11:0] Q         = 12'd3329;
    localparam logic [11:0] N_INV     = 12'd3303;
    localparam logic [23:0] Q24       = 24'd3329;
    localparam logic [38:0] BARRETT_M = 39'd20158;   // floor(2^26 / Q)

    typedef enum logic [1:0] {LOAD, COMPUTE, SCALE, OUT} state_t;
    state_t state_reg, state_next;

    logic [11:0] store [0:255];
    logic [11:0] zeta_rom [0:127];
    logic [7:0]  idx_reg;
    logic [2:0]  layer_reg;
    logic [6:0]  bcnt_reg;
    logic [6:0]  k_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic [11:0] out_data_reg;

    // Exact reduction of any product below 2^24: the estimate is short by at most one Q.
    function automatic logic [11:0] mod_q(input logic [23:0] x);
        logic [38:0] p;
        logic [12:0] qe;
        logic [23:0] r;
        p  = {15'd0, x} * BARRETT_M;
        qe = p[38:26];
        r  = x - ({11'd0, qe} * Q24);
        if (r >= Q24)
            r = r - Q24;
        return r[11:0];
    endfunction

    function automatic logic [11:0] zeta_calc(input int i);
        int br;
        int acc;
        br = 0;
        for (int b = 0; b < 7; b++)
            br = br | (((i >> b) & 1) << (6 - b));
        acc = 1;
        for (int e = 0; e < br; e++)
            acc = (acc * 17) % 3329;
        return 12'(acc);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 128; gi++) begin : g_zeta
            localparam logic [11:0] ZV = zeta_calc(gi);
            assign zeta_rom[gi] = ZV;
        end
    endgenerate

    // Butterfly addressing: j_lo is the butterfly counter with a zero inserted at the len bit.
    logic [7:0]  len_v, mask, b8, j_lo, j_hi;
    logic [11:0] bf_a, bf_b, bf_sum, bf_diff, bf_prod, sc_val, in_red;
    logic [12:0] sum13;
    logic        in_fire, out_fire, layer_done, last_layer, block_done;

    always_comb begin
        len_v   = 8'd2 << layer_reg;
        mask    = len_v - 8'd1;
        b8      = {1'b0, bcnt_reg};
        j_lo    = ((b8 & ~mask) << 1) | (b8 & mask);
        j_hi    = j_lo | len_v;
        bf_a    = store[j_lo];
        bf_b    = store[j_hi];
        sum13   = {1'b0, bf_a} + {1'b0, bf_b};
        bf_sum  = (sum13 >= {1'b0, Q}) ? 12'(sum13 - {1'b0, Q}) : sum13[11:0];
        bf_diff = (bf_b >= bf_a) ? (bf_b - bf_a) : (bf_b - bf_a + Q);
        bf_prod = mod_q({12'd0, zeta_rom[k_reg]} * {12'd0, bf_diff});
        sc_val  = mod_q({12'd0, store[idx_reg]} * {12'd0, N_INV});
        in_red  = (in_data >= Q) ? (in_data - Q) : in_data;
    end

    assign in_fire    = (state_reg == LOAD) && in_valid && in_ready_reg;
    assign out_fire   = (state_reg == OUT) && out_valid_reg && out_ready;
    assign layer_done = (bcnt_reg == 7'd127);
    assign last_layer = (layer_reg == 3'd6);
    assign block_done = ((bcnt_reg & mask[6:0]) == mask[6:0]);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD:    if (in_fire && idx_reg == 8'd255) state_next = COMPUTE;
            COMPUTE: if (layer_done && last_layer)     state_next = SCALE;
            SCALE:   if (idx_reg == 8'd255)            state_next = OUT;
            OUT:     if (out_fire && idx_reg == 8'd255) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= LOAD;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg       <= 8'd0;
            layer_reg     <= 3'd0;
            bcnt_reg      <= 7'd0;
            k_reg         <= 7'd127;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 12'd0;
        end else begin
            in_ready_reg <= (state_next == LOAD);
            case (state_reg)
                LOAD: if (in_fire) idx_reg <= idx_reg + 8'd1;
                COMPUTE: begin
                    bcnt_reg <= bcnt_reg + 7'd1;
                    if (block_done)
                        k_reg <= k_reg - 7'd1;
                    if (layer_done)
                        layer_reg <= last_layer ? 3'd0 : layer_reg + 3'd1;
                end
                SCALE: idx_reg <= idx_reg + 8'd1;
                OUT: begin
                    // First OUT cycle fetches f[0]; afterwards each transfer fetches the next index.
                    if (!out_valid_reg) begin
                        out_data_reg  <= store[idx_reg];
                        out_valid_reg <= 1'b1;
                    end else if (out_ready) begin
                        if (idx_reg == 8'd255) begin
                            out_valid_reg <= 1'b0;
                            idx_reg       <= 8'd0;
                            k_reg         <= 7'd127;
                        end else begin
                            idx_reg      <= idx_reg + 8'd1;
                            out_data_reg <= store[idx_reg + 8'd1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state_reg)
            LOAD: if (in_fire) store[idx_reg] <= in_red;
            COMPUTE: begin
                store[j_lo] <= bf_sum;
                store[j_hi] <= bf_prod;
            end
            SCALE: store[idx_reg] <= sc_val;
            default: ;
        endcase
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = (state_reg == COMPUTE) || (state_reg == SCALE);
endmodule

// File: tb/tb_inv_ntt_core.sv
// Bench for inv_ntt_core: directed patterns plus random polynomials pushed through a
// forward NTT model, so every expected output is the original normal-domain polynomial.
module tb_inv_ntt_core;
    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = 12'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic        busy;

    inv_ntt_core dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int vin [256];
    int vexp [256];
    int t_last = 0;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int zeta_of(input int k);
        int br = 0;
        int acc = 1;
        for (int b = 0; b < 7; b++)
            br = br | (((k >> b) & 1) << (6 - b));
        for (int e = 0; e < br; e++)
            acc = (acc * 17) % Q;
        return acc;
    endfunction

    // Forward NTT of vexp into vin; the core must undo it exactly.
    task automatic fwd_ntt();
        int f [256];
        int k = 1;
        int z, t;
        for (int i = 0; i < 256; i++) f[i] = vexp[i];
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int start = 0; start < 256; start += 2 * len) begin
                z = zeta_of(k);
                k++;
                for (int j = start; j < start + len; j++) begin
                    t = (z * f[j + len]) % Q;
                    f[j + len] = (f[j] - t + Q) % Q;
                    f[j] = (f[j] + t) % Q;
                end
            end
        end
        for (int i = 0; i < 256; i++) vin[i] = f[i];
    endtask

    task automatic load_poly(input bit gaps);
        int i = 0;
        int guard = 0;
        bit fire;
        while (i < 256 && guard < 5000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = 12'(vin[i]);
            fire     = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) i++;
            guard++;
        end
        in_valid = 1'b0;
        t_last   = cyc;
        if (i < 256) check("load_timeout", i, 256);
        check("busy_after_load", int'(busy), 1);
        check("in_ready_after_load", int'(in_ready), 0);
    endtask

    task automatic wait_out();
        int guard = 0;
        while (!out_valid && guard < 3000) begin
            in_valid  = $urandom_range(0, 1);
            in_data   = 12'($urandom_range(0, 4095));
            out_ready = $urandom_range(0, 1);
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        check("first_out_valid", int'(out_valid), 1);
        check("latency", cyc - t_last, 1153);
    endtask

    task automatic collect(input int n, input bit stall);
        int i = 0;
        int guard = 0;
        int held = 0;
        bit was_stall = 1'b0;
        while (i < n && guard < 10000) begin
            if (was_stall) begin
                check("hold_data", int'(out_data), held);
                check("hold_valid", int'(out_valid), 1);
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                check($sformatf("out[%0d]", i), int'(out_data), vexp[i]);
                i++;
                was_stall = 1'b0;
            end else begin
                was_stall = out_valid;
                held      = int'(out_data);
            end
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        if (i < n) check("collect_timeout", i, n);
    endtask

    task automatic run_poly(input string name, input bit gaps, input bit stall);
        int m0 = miscompares;
        load_poly(gaps);
        wait_out();
        collect(256, stall);
        check("out_valid_after_last", int'(out_valid), 0);
        check("in_ready_reopen", int'(in_ready), 1);
        $display("poly %-10s done: %0d new miscompares", name, miscompares - m0);
    endtask

    task automatic set_pattern(input int even_v, input int odd_v);
        for (int i = 0; i < 256; i++) begin
            vin[i]  = (i % 2 == 0) ? even_v : odd_v;
            vexp[i] = 0;
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < 256; i++) vexp[i] = $urandom_range(0, Q - 1);
        fwd_ntt();
        for (int i = 0; i < 256; i++)
            if (vin[i] < 4096 - Q && $urandom_range(0, 3) == 0) vin[i] = vin[i] + Q;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_in_ready"}, int'(in_ready), 0);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", int'(in_ready), 1);

        set_pattern(0, 0);
        run_poly("zeros", 1'b0, 1'b0);

        set_pattern(1, 0);
        vexp[0] = 1;
        run_poly("const1", 1'b0, 1'b0);

        set_pattern(0, 1);
        vexp[1] = 1;
        run_poly("x", 1'b1, 1'b0);

        set_pattern(3328, 0);
        vexp[0] = 3328;
        run_poly("minus1", 1'b0, 1'b1);

        set_pattern(3329, 0);
        run_poly("q_evens", 1'b0, 1'b0);

        for (int r = 0; r < 2; r++) begin
            set_random();
            run_poly($sformatf("random%0d", r), 1'b1, 1'b1);
        end

        // Abort mid-COMPUTE, then a clean run must be bit-exact.
        set_pattern(1, 0);
        vexp[0] = 1;
        load_poly(1'b0);
        repeat (399) @(posedge clk);
        #1;
        check("busy_before_abort", int'(busy), 1);
        pulse_reset("abort_compute");
        run_poly("const1_rc", 1'b0, 1'b0);

        // Abort in OUT after 100 transfers.
        set_random();
        load_poly(1'b0);
        wait_out();
        collect(100, 1'b1);
        pulse_reset("abort_out");
        set_pattern(1, 0);
        vexp[0] = 1;
        run_poly("const1_ro", 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
